hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS core. It is the consumer end of the opcode decoder's control bundle.
- It takes the decoded ID-stage control bits and register fields and tracks their own EX/MEM/WB copies internally.
- Outputs: PC/IF-ID write enables, IF/ID flush, ID/EX bubble insertion and EX-stage forwarding selects.
- Sits beside the ID stage; drives the PC register, IF/ID register, ID/EX control mux and both ALU operand muxes.

Parameters:
- REG_AW, 5, register-address width.
- STALL_MAX, 1, maximum consecutive load-use stall cycles; legal value 1 only; assertion otherwise.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-low reset.
- start_i  in  1  core run enable; pipeline is frozen while low.
- id_valid_i  in  1  ID holds a real instruction (0 = bubble).
- id_regwrite_i  in  1  decoded RegWrite.
- id_memread_i  in  1  decoded MemRead.
- id_regdst_i  in  1  decoded RegDst.
- id_branch_i  in  1  decoded Branch (beq).
- id_jump_i  in  1  opcode is jump.
- id_eq_i  in  1  beq comparand equality, resolved in ID.
- id_rs_i  in  REG_AW  rs field.
- id_rt_i  in  REG_AW  rt field.
- id_rd_i  in  REG_AW  rd field.
- pc_write_o  out  1  PC load enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID cleared to NOP on next edge.
- idex_bubble_o  out  1  zero all control bits into ID/EX.
- fwd_a_o  out  2  ALU src A select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- fwd_b_o  out  2  ALU src B select, same encoding.

Behaviour:
- Reset (rst_i=0 at an edge):
  - FSM goes to IDLE.
  - All internal stage registers clear: valid, regwrite and memread = 0, dest = 0.
  - Outputs in IDLE: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=1, fwd_a_o=fwd_b_o=00.
- Reset mid-operation discards all tracked instructions with no residual stall.
- FSM states:
  - IDLE: enter RUN when start_i=1; stay otherwise.
  - RUN: go to STALL when a load-use hazard is detected; otherwise stay.
  - STALL: return to RUN unconditionally next cycle.
  - start_i=0 in RUN or STALL: go to IDLE and freeze the tracked stages (no shift).
- Destination register: id_dest = id_regdst_i ? id_rd_i : id_rt_i.
- Stage tracking: each non-frozen cycle, EX<=ID (or bubble), MEM<=EX, WB<=MEM. Each stage carries valid, regwrite, memread, dest, plus rs/rt for the EX stage.
- Load-use hazard (combinational, RUN only):
  - Condition: id_valid_i & ex_valid & ex_memread & ex_dest!=0 & (ex_dest==id_rs_i | ex_dest==id_rt_i).
  - Response in the same cycle: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. EX loads a bubble at the next edge.
- STALL state:
  - The load has advanced to MEM, so the hazard can no longer be asserted.
  - Outputs are normal; the stalled instruction enters EX.
  - Exactly one bubble per load-use pair.
- Control flow (RUN or STALL, no hazard this cycle):
  - Taken beq (id_branch_i & id_eq_i & id_valid_i) asserts ifid_flush_o=1, with pc_write_o=1.
  - Jump (id_jump_i & id_valid_i) asserts ifid_flush_o=1.
  - Load-use hazard has priority over flush: flush is suppressed while stalled and re-evaluated after the stall.
- Default in RUN: pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=~id_valid_i.
- Forwarding for EX operand A (ex_rs); operand B uses ex_rt identically:
  - 10 if mem_valid & mem_regwrite & mem_dest!=0 & mem_dest==ex_rs.
  - else 01 if wb_valid & wb_regwrite & wb_dest!=0 & wb_dest==ex_rs.
  - else 00.
  - EX/MEM has priority over MEM/WB when both match.
- Register 0 never matches in stall or forwarding logic.
- Forward selects are 00 whenever EX holds a bubble.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined, add outputs stall_cnt_o[15:0] and flush_cnt_o[15:0].
  - Each increments once per cycle that a load-use stall or ifid_flush_o is asserted, respectively.
  - Counters saturate at 16'hFFFF and clear on reset.
- Without the macro, neither the ports nor the counters exist; core behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - Forward-select constants FWD_REG=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
  - FSM state encodings HZ_IDLE, HZ_RUN, HZ_STALL.
  - REG_AW default.
- One sub-module, fwd_sel: purely combinational per-operand priority compare, instantiated twice (A and B).

Test Plan:
- Reset with rst_i=0 for 2 cycles, then start_i=1 -> outputs at reset values during reset; pc_write_o=1 on the first cycle after start.
- "lw $2,0($1)" then "add $3,$2,$4" -> exactly 1 cycle with pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; next cycle when add is in EX, fwd_a_o=01.
- "add $2,..", "sub $2,..", "or $5,$2,$2" -> fwd_a_o=fwd_b_o=10 (EX/MEM priority over MEM/WB).
- Instruction writing $0 followed by a read of $0 -> fwd_a_o=00, no stall.
- beq with id_eq_i=1 -> ifid_flush_o=1 for 1 cycle; same beq as the load-use consumer of a lw -> stall first, flush on the following cycle.
- rst_i=0 asserted during STALL -> IDLE next edge, all tracked stages cleared, no forwarding from pre-reset instructions after restart.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: forwarding-select encodings, hazard FSM
// states and the default register-address width.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [1:0] {
    HZ_IDLE  = 2'd0,
    HZ_RUN   = 2'd1,
    HZ_STALL = 2'd2
  } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding priority compare: EX/MEM beats MEM/WB, $0 never matches,
// and a bubble in EX always reads the register file.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              ex_vld,
  input  logic [REG_AW-1:0] ex_src,
  input  logic              mem_vld,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              wb_vld,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_dest,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_REG;
    if (ex_vld) begin
      if (mem_vld && mem_regwrite && (mem_dest != '0) && (mem_dest == ex_src)) begin
        sel = FWD_MEM;
      end else if (wb_vld && wb_regwrite && (wb_dest != '0) && (wb_dest == ex_src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: load-use stall, branch/jump
// flush, EX forwarding. Optional perf counters under `HAZ_PERF_CNT_EN.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int STALL_MAX = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              id_valid_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_regdst_i,
  input  logic              id_branch_i,
  input  logic              id_jump_i,
  input  logic              id_eq_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
`endif
);

  // A single bubble always suffices because the load reaches MEM after one cycle.
  generate
    if (STALL_MAX != 1) begin : g_bad_stall_max
      $error("hazard_ctrl: STALL_MAX must be 1");
    end
  endgenerate

  hz_state_t state_q, state_d;

  // Tracked stages: _p0 = EX, _p1 = MEM, _p2 = WB
  logic              vld_p0, regwrite_p0, memread_p0;
  logic [REG_AW-1:0] dest_p0, rs_p0, rt_p0;
  logic              vld_p1, regwrite_p1;
  logic [REG_AW-1:0] dest_p1;
  logic              vld_p2, regwrite_p2;
  logic [REG_AW-1:0] dest_p2;

  logic              active;
  logic              load_use;
  logic              redirect;
  logic [REG_AW-1:0] id_dest;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  assign active   = ((state_q == HZ_RUN) || (state_q == HZ_STALL)) && start_i;
  assign id_dest  = id_regdst_i ? id_rd_i : id_rt_i;
  assign redirect = id_valid_i && ((id_branch_i && id_eq_i) || id_jump_i);
  assign load_use = (state_q == HZ_RUN) && start_i && id_valid_i && vld_p0 && memread_p0 &&
                    (dest_p0 != '0) && ((dest_p0 == id_rs_i) || (dest_p0 == id_rt_i));

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_IDLE:  if (start_i) state_d = HZ_RUN;
      HZ_RUN:   if (!start_i) state_d = HZ_IDLE;
                else if (load_use) state_d = HZ_STALL;
      HZ_STALL: state_d = start_i ? HZ_RUN : HZ_IDLE;
      default:  state_d = HZ_IDLE;
    endcase
  end

  always_comb begin
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b1;
    fwd_a_o       = FWD_REG;
    fwd_b_o       = FWD_REG;
    if (active) begin
      fwd_a_o = fwd_a_raw;
      fwd_b_o = fwd_b_raw;
      if (!load_use) begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = redirect;
        idex_bubble_o = ~id_valid_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= HZ_IDLE;
    else        state_q <= state_d;
  end

  // ID -> EX -> MEM -> WB shift; frozen whenever the core is not running
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vld_p0 <= 1'b0; regwrite_p0 <= 1'b0; memread_p0 <= 1'b0;
      dest_p0 <= '0;  rs_p0 <= '0;         rt_p0 <= '0;
      vld_p1 <= 1'b0; regwrite_p1 <= 1'b0; dest_p1 <= '0;
      vld_p2 <= 1'b0; regwrite_p2 <= 1'b0; dest_p2 <= '0;
    end else if (active) begin
      vld_p2      <= vld_p1;
      regwrite_p2 <= regwrite_p1;
      dest_p2     <= dest_p1;
      vld_p1      <= vld_p0;
      regwrite_p1 <= regwrite_p0;
      dest_p1     <= dest_p0;
      if (load_use || !id_valid_i) begin
        vld_p0 <= 1'b0; regwrite_p0 <= 1'b0; memread_p0 <= 1'b0;
        dest_p0 <= '0;  rs_p0 <= '0;         rt_p0 <= '0;
      end else begin
        vld_p0      <= 1'b1;
        regwrite_p0 <= id_regwrite_i;
        memread_p0  <= id_memread_i;
        dest_p0     <= id_dest;
        rs_p0       <= id_rs_i;
        rt_p0       <= id_rt_i;
      end
    end
  end

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_vld(vld_p0), .ex_src(rs_p0),
    .mem_vld(vld_p1), .mem_regwrite(regwrite_p1), .mem_dest(dest_p1),
    .wb_vld(vld_p2), .wb_regwrite(regwrite_p2), .wb_dest(dest_p2),
    .sel(fwd_a_raw)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_vld(vld_p0), .ex_src(rt_p0),
    .mem_vld(vld_p1), .mem_regwrite(regwrite_p1), .mem_dest(dest_p1),
    .wb_vld(vld_p2), .wb_regwrite(regwrite_p2), .wb_dest(dest_p2),
    .sel(fwd_b_raw)
  );

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (load_use)     stall_cnt_o <= sat_inc(stall_cnt_o);
      if (ifid_flush_o) flush_cnt_o <= sat_inc(flush_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues hand-computed expectations
// per cycle, a monitor pops and compares them on the falling edge.
module tb_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i, start_i;
  logic       id_valid_i, id_regwrite_i, id_memread_i, id_regdst_i;
  logic       id_branch_i, id_jump_i, id_eq_i;
  logic [4:0] id_rs_i, id_rt_i, id_rd_i;
  logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
  logic [1:0] fwd_a_o, fwd_b_o;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_o, flush_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      nm;
    logic       chk_ctl;
    logic       pcw, ifw, fl, bub;
    logic [1:0] fa, fb;
  } exp_t;

  exp_t sb[$];

  hazard_ctrl #(.REG_AW(5), .STALL_MAX(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_valid_i(id_valid_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .id_regdst_i(id_regdst_i),
    .id_branch_i(id_branch_i), .id_jump_i(id_jump_i), .id_eq_i(id_eq_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queued=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input string fld, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%b required=%b at %0t", nm, fld, act, req, $time);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_ctl) begin
        cmp(e.nm, "pc_write",    {1'b0, pc_write_o},    {1'b0, e.pcw});
        cmp(e.nm, "ifid_write",  {1'b0, ifid_write_o},  {1'b0, e.ifw});
        cmp(e.nm, "ifid_flush",  {1'b0, ifid_flush_o},  {1'b0, e.fl});
        cmp(e.nm, "idex_bubble", {1'b0, idex_bubble_o}, {1'b0, e.bub});
      end
      cmp(e.nm, "fwd_a", fwd_a_o, e.fa);
      cmp(e.nm, "fwd_b", fwd_b_o, e.fb);
    end
  end

  task automatic id_set(input logic v, rw, mr, rdst, br, jp, eq, input logic [4:0] rs, rt, rd);
    id_valid_i = v;  id_regwrite_i = rw; id_memread_i = mr; id_regdst_i = rdst;
    id_branch_i = br; id_jump_i = jp;    id_eq_i = eq;
    id_rs_i = rs;    id_rt_i = rt;       id_rd_i = rd;
  endtask

  task automatic id_nop();                               id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   endtask
  task automatic id_r(input logic [4:0] rs, rt, rd);     id_set(1, 1, 0, 1, 0, 0, 0, rs, rt, rd); endtask
  task automatic id_lw(input logic [4:0] rs, rt);        id_set(1, 1, 1, 0, 0, 0, 0, rs, rt, 0);  endtask
  task automatic id_beq(input logic [4:0] rs, rt, input logic eq); id_set(1, 0, 0, 0, 1, 0, eq, rs, rt, 0); endtask
  task automatic id_j();                                 id_set(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);   endtask

  // Queue one cycle's expectation, then advance to just after the next rising edge.
  task automatic cyc_x(input string nm, input logic cc, input logic pcw, ifw, fl, bub,
                       input logic [1:0] fa, fb);
    exp_t e;
    e.nm = nm; e.chk_ctl = cc; e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.bub = bub;
    e.fa = fa; e.fb = fb;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input string nm, input logic pcw, ifw, fl, bub, input logic [1:0] fa, fb);
    cyc_x(nm, 1'b1, pcw, ifw, fl, bub, fa, fb);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0;
    id_nop();
    @(posedge clk_i); #1;

    // Reset and start-up
    cyc("rst_0", 0, 0, 0, 1, 2'b00, 2'b00);
    cyc("rst_1", 0, 0, 0, 1, 2'b00, 2'b00);
    rst_i = 1'b1; start_i = 1'b1;
    cyc("idle_start", 0, 0, 0, 1, 2'b00, 2'b00);

    // lw $2,0($1) ; add $3,$2,$4
    id_lw(1, 2);     cyc("lu_lw",        1, 1, 0, 0, 2'b00, 2'b00);
    id_r(2, 4, 3);   cyc("lu_hazard",    0, 0, 0, 1, 2'b00, 2'b00);
                     cyc("lu_stall_rel", 1, 1, 0, 0, 2'b00, 2'b00);
    id_nop();        cyc("lu_fwd_wb",    1, 1, 0, 1, 2'b01, 2'b00);
                     cyc("lu_drain0",    1, 1, 0, 1, 2'b00, 2'b00);
                     cyc("lu_drain1",    1, 1, 0, 1, 2'b00, 2'b00);

    // add $2 ; sub $2 ; or $5,$2,$2 -> EX/MEM wins over MEM/WB
    id_r(1, 1, 2);   cyc("pri_add",      1, 1, 0, 0, 2'b00, 2'b00);
    id_r(1, 1, 2);   cyc("pri_sub",      1, 1, 0, 0, 2'b00, 2'b00);
    id_r(2, 2, 5);   cyc("pri_or",       1, 1, 0, 0, 2'b00, 2'b00);
    id_nop();        cyc("pri_fwd_mem",  1, 1, 0, 1, 2'b10, 2'b10);
                     cyc("pri_drain0",   1, 1, 0, 1, 2'b00, 2'b00);
                     cyc("pri_drain1",   1, 1, 0, 1, 2'b00, 2'b00);

    // add $7 ; nop ; and $8,$1,$7 -> operand B from MEM/WB
    id_r(1, 1, 7);   cyc("wbb_add",      1, 1, 0, 0, 2'b00, 2'b00);
    id_nop();        cyc("wbb_gap",      1, 1, 0, 1, 2'b00, 2'b00);
    id_r(1, 7, 8);   cyc("wbb_and",      1, 1, 0, 0, 2'b00, 2'b00);
    id_nop();        cyc("wbb_fwd_b",    1, 1, 0, 1, 2'b00, 2'b01);
                     cyc("wbb_drain0",   1, 1, 0, 1, 2'b00, 2'b00);
                     cyc("wbb_drain1",   1, 1, 0, 1, 2'b00, 2'b00);

    // lw $0 ; add $3,$0,$0 -> no stall, no forwarding
    id_lw(1, 0);     cyc("r0_lw",        1, 1, 0, 0, 2'b00, 2'b00);
    id_r(0, 0, 3);   cyc("r0_no_stall",  1, 1, 0, 0, 2'b00, 2'b00);
    id_nop();        cyc("r0_no_fwd",    1, 1, 0, 1, 2'b00, 2'b00);
                     cyc("r0_drain0",    1, 1, 0, 1, 2'b00, 2'b00);
                     cyc("r0_drain1",    1, 1, 0, 1, 2'b00, 2'b00);

    // Control flow
    id_beq(1, 1, 1); cyc("beq_taken",    1, 1, 1, 0, 2'b00, 2'b00);
    id_nop();        cyc("beq_after",    1, 1, 0, 1, 2'b00, 2'b00);
    id_beq(1, 3, 0); cyc("beq_not_tkn",  1, 1, 0, 0, 2'b00, 2'b00);
    id_j();          cyc("jump",         1, 1, 1, 0, 2'b00, 2'b00);
    id_nop();        cyc("jump_after",   1, 1, 0, 1, 2'b00, 2'b00);

    // lw $2 ; beq $2,$3 taken -> stall first, flush next cycle
    id_lw(1, 2);     cyc("lb_lw",        1, 1, 0, 0, 2'b00, 2'b00);
    id_beq(2, 3, 1); cyc("lb_stall",     0, 0, 0, 1, 2'b00, 2'b00);
                     cyc("lb_flush",     1, 1, 1, 0, 2'b00, 2'b00);
    id_nop();        cyc("lb_fwd_wb",    1, 1, 0, 1, 2'b01, 2'b00);

    // Reset while in STALL
    id_r(1, 1, 6);   cyc("rs_add6",      1, 1, 0, 0, 2'b00, 2'b00);
    id_lw(1, 2);     cyc("rs_lw",        1, 1, 0, 0, 2'b00, 2'b00);
    id_r(2, 6, 3);   cyc("rs_hazard",    0, 0, 0, 1, 2'b00, 2'b00);
    rst_i = 1'b0;    cyc_x("rs_in_stall", 1'b0, 0, 0, 0, 0, 2'b00, 2'b00);
    rst_i = 1'b1;
    id_nop();        cyc("rs_idle",      0, 0, 0, 1, 2'b00, 2'b00);
    id_r(2, 6, 3);   cyc("rs_restart",   1, 1, 0, 0, 2'b00, 2'b00);
    id_nop();        cyc("rs_no_fwd",    1, 1, 0, 1, 2'b00, 2'b00);
                     cyc("rs_drain",     1, 1, 0, 1, 2'b00, 2'b00);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk_i);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
